score_status_tracker: RTL

- Sits directly downstream of the score/status priority selector.
- Consumes its single arbitrated 8-bit event code and data-ready strobe.
- Keeps the game's 4-digit BCD score and life count, and runs the game-status FSM: playing, hit cooldown, game over, win.
- Outputs feed the score/lives display drawers and the game-over/win screen logic.

---
 rtl/score_pkg.sv | 20 ++
 rtl/score_status_tracker_if.sv | 25 ++
 rtl/bcd_add_sat.sv | 30 +++
 rtl/score_status_tracker.sv | 120 ++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared event codes, game status encoding and BCD digit type.
package score_pkg;

  localparam logic [7:0] EV_WALL       = 8'h01;
  localparam logic [7:0] EV_ENEMY      = 8'h02;
  localparam logic [7:0] EV_HIT        = 8'h03;
  localparam logic [7:0] EV_BONUS      = 8'h04;
  localparam logic [7:0] EV_LEVEL_DONE = 8'h05;
  localparam logic [7:0] EV_NONE       = 8'hFF;

  typedef enum logic [1:0] {
    PLAYING      = 2'd0,
    HIT_COOLDOWN = 2'd1,
    GAME_OVER    = 2'd2,
    WIN          = 2'd3
  } status_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/score_status_tracker_if.sv
// Event input / status output bundle between the priority selector,
// the tracker and the display/screen logic.
interface score_status_tracker_if;
  logic [7:0]  event_code;
  logic        event_dr;
  logic        restart;
  logic [15:0] score_bcd;
  logic [3:0]  lives;
  logic        hit_flash;
  logic        game_over;
  logic        win;
  logic        event_ack;

  // Event source side
  modport master (
    output event_code, event_dr, restart,
    input  score_bcd, lives, hit_flash, game_over, win, event_ack
  );

  // Tracker side
  modport slave (
    input  event_code, event_dr, restart,
    output score_bcd, lives, hit_flash, game_over, win, event_ack
  );
endinterface

// File: rtl/bcd_add_sat.sv
// 4-digit BCD plus one BCD digit placed at digit position pos_i,
// ripple carry per digit, saturating at 9999 on carry out of thousands.
module bcd_add_sat
  import score_pkg::*;
(
  input  logic [15:0] a_i,
  input  bcd_digit_t  addend_i,
  input  logic [1:0]  pos_i,
  output logic [15:0] sum_o
);

  logic [15:0] raw;
  logic [4:0]  t;
  logic        c;

  // Digit-serial ripple add; a carry out of the top digit forces 9999
  always_comb begin
    raw = '0;
    t   = '0;
    c   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, a_i[4*i +: 4]} + {4'd0, c} +
          ((pos_i == i[1:0]) ? {1'b0, addend_i} : 5'd0);
      c = (t > 5'd9);
      raw[4*i +: 4] = c ? 4'(t - 5'd10) : t[3:0];
    end
    sum_o = c ? 16'h9999 : raw;
  end

endmodule

// File: rtl/score_status_tracker.sv
// Game score / lives keeper and status FSM fed by the arbitrated event stream.
module score_status_tracker
  import score_pkg::*;
#(
  parameter int LIVES_INIT      = 3,
  parameter int LIVES_MAX       = 9,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  score_status_tracker_if.slave bus
);

  localparam int            CW        = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]    LIVES_RST = 4'(LIVES_INIT);
  localparam logic [3:0]    LIVES_TOP = 4'(LIVES_MAX);

  status_t       state_q, state_d;
  logic [15:0]   score_q, score_d;
  logic [3:0]    lives_q, lives_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          ack_q,   ack_d;

  logic [15:0]   score_inc;
  logic [1:0]    add_pos;
  logic          active;

  // ENEMY adds one at the tens digit, everything else at units
  assign add_pos = (bus.event_code == EV_ENEMY) ? 2'd1 : 2'd0;

  bcd_add_sat u_add (
    .a_i      (score_q),
    .addend_i (4'd1),
    .pos_i    (add_pos),
    .sum_o    (score_inc)
  );

  assign active = (state_q == PLAYING) || (state_q == HIT_COOLDOWN);

  // Next-state: cooldown tick first, then event (may override to WIN/GAME_OVER),
  // restart only honoured in the terminal states and drops any same-cycle event
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;

    if (state_q == HIT_COOLDOWN) begin
      if (cnt_q == '0) state_d = PLAYING;
      else             cnt_d   = cnt_q - CW'(1);
    end

    if (active && bus.event_dr) begin
      case (bus.event_code)
        EV_WALL, EV_ENEMY: begin
          score_d = score_inc;
          ack_d   = 1'b1;
        end
        EV_HIT: begin
          // invulnerable while cooling down: no loss, no ack
          if (state_q == PLAYING) begin
            ack_d = 1'b1;
            if (lives_q > 4'd1) begin
              lives_d = lives_q - 4'd1;
              cnt_d   = CNT_LOAD;
              state_d = HIT_COOLDOWN;
            end else begin
              lives_d = 4'd0;
              state_d = GAME_OVER;
            end
          end
        end
        EV_BONUS: begin
          lives_d = (lives_q >= LIVES_TOP) ? LIVES_TOP : lives_q + 4'd1;
          ack_d   = 1'b1;
        end
        EV_LEVEL_DONE: begin
          state_d = WIN;
          ack_d   = 1'b1;
        end
        EV_NONE: ;
        default: ;
      endcase
    end

    if (!active && bus.restart) begin
      state_d = PLAYING;
      score_d = '0;
      lives_d = LIVES_RST;
      cnt_d   = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAYING;
      score_q <= '0;
      lives_q <= LIVES_RST;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.lives     = lives_q;
  assign bus.hit_flash = (state_q == HIT_COOLDOWN);
  assign bus.game_over = (state_q == GAME_OVER);
  assign bus.win       = (state_q == WIN);
  assign bus.event_ack = ack_q;

endmodule
